// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch front end: line fetch, split, in-order buffer to decode
module fetch_buffer #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] WFI_INST = 32'h10500073
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [63:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        dec_ready,
   output logic        halted
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2,
      S_HALTED  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [31:0]       fetch_pc;
   logic [31:0]       fetch_pc_next;

   // Instruction queue storage; entries carry their own PC
   logic [31:0]       inst_mem [DEPTH];
   logic [31:0]       pc_mem   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  free_cnt;
   logic              free_ok;

   // Response split results
   logic [1:0]        push_n;
   logic [31:0]       push_inst0;
   logic [31:0]       push_pc0;
   logic [31:0]       push_inst1;
   logic [31:0]       push_pc1;
   logic              wfi_seen;
   logic [31:0]       pc_step;

   // FSM-driven controls
   logic              do_push;
   logic              flush;
   logic              pop;
   logic [1:0]        push_cnt;

   logic [31:0]       resp_lo;
   logic [31:0]       resp_hi;

   assign resp_lo       = imem_resp_data[31:0];
   assign resp_hi       = imem_resp_data[63:32];
   assign free_cnt      = CNT_W'(DEPTH) - count;
   assign free_ok       = (free_cnt >= CNT_W'(2));
   assign imem_req_addr = fetch_pc & 32'hFFFF_FFF8;
   assign halted        = (state == S_HALTED);
   assign inst_valid    = (count != '0);
   assign inst          = inst_valid ? inst_mem[rd_ptr] : 32'h0;
   assign inst_pc       = inst_valid ? pc_mem[rd_ptr]   : 32'h0;
   assign pop           = inst_valid && dec_ready;
   assign push_cnt      = do_push ? push_n : 2'd0;

   // Split the returned line into the entries to enqueue, depending on where fetch_pc sits in it
   always_comb begin
      push_n     = 2'd0;
      push_inst0 = 32'h0;
      push_pc0   = 32'h0;
      push_inst1 = 32'h0;
      push_pc1   = 32'h0;
      wfi_seen   = 1'b0;
      pc_step    = 32'd0;
      if (fetch_pc[2]) begin
         push_n     = 2'd1;
         push_inst0 = resp_hi;
         push_pc0   = fetch_pc;
         wfi_seen   = (resp_hi == WFI_INST);
         pc_step    = 32'd4;
      end else begin
         push_inst0 = resp_lo;
         push_pc0   = fetch_pc;
         pc_step    = 32'd8;
         if (resp_lo == WFI_INST) begin
            push_n   = 2'd1;
            wfi_seen = 1'b1;
         end else begin
            push_n     = 2'd2;
            push_inst1 = resp_hi;
            push_pc1   = fetch_pc + 32'd4;
            wfi_seen   = (resp_hi == WFI_INST);
         end
      end
   end

   // Next-state, request and push/flush decisions; redirect overrides every state
   always_comb begin
      state_next     = state;
      fetch_pc_next  = fetch_pc;
      imem_req_valid = 1'b0;
      do_push        = 1'b0;
      flush          = 1'b0;
      if (redirect_valid) begin
         flush         = 1'b1;
         fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
         if (((state == S_WAIT) || (state == S_DISCARD)) && !imem_resp_valid) begin
            state_next = S_DISCARD;
         end else begin
            state_next = S_IDLE;
         end
      end else begin
         case (state)
            S_IDLE: begin
               imem_req_valid = free_ok && !reset;
               if (free_ok && imem_req_ready) begin
                  state_next = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  do_push       = 1'b1;
                  fetch_pc_next = fetch_pc + pc_step;
                  state_next    = wfi_seen ? S_HALTED : S_IDLE;
               end
            end
            S_DISCARD: begin
               if (imem_resp_valid) begin
                  state_next = S_IDLE;
               end
            end
            S_HALTED: begin
               state_next = S_HALTED;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   // State and fetch PC registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue and ignores the pop
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
      end
   end

   // Queue storage writes, up to two entries per response
   always_ff @(posedge clock) begin
      if (do_push) begin
         inst_mem[wr_ptr] <= push_inst0;
         pc_mem[wr_ptr]   <= push_pc0;
         if (push_n == 2'd2) begin
            inst_mem[wr_ptr + PTR_W'(1)] <= push_inst1;
            pc_mem[wr_ptr + PTR_W'(1)]   <= push_pc1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized and directed checks of fetch_buffer against a queue model
module tb_fetch_buffer;

   localparam int          DEPTH = 8;
   localparam logic [31:0] WFI   = 32'h10500073;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [63:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        dec_ready;
   logic        halted;

   always #5 clock = ~clock;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0), .WFI_INST(WFI)) dut (
      .clock           (clock),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_valid      (inst_valid),
      .dec_ready       (dec_ready),
      .halted          (halted)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory: 64 lines, address bits [8:3] select the line
   logic [63:0] mem [64];
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          lat_min;
   int          lat_max;
   int          ready_pct;

   // Reference model: fetch pointer, expected queue of {pc, inst}, and fetch status flags
   logic [31:0] m_pc;
   logic [63:0] m_q[$];
   bit          m_wait;
   bit          m_discard;
   bit          m_halted;

   logic [63:0] req_log[$];
   logic [63:0] pop_log[$];

   function automatic logic [63:0] req_at(int i);
      if (i < req_log.size()) return req_log[i];
      return 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   function automatic logic [63:0] pop_at(int i);
      if (i < pop_log.size()) return pop_log[i];
      return 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   function automatic logic [31:0] rand_word(bit allow_wfi);
      logic [31:0] w;
      w = $urandom;
      if (w == WFI) w = w ^ 32'h1;
      if (allow_wfi && ($urandom_range(9) == 0)) w = WFI;
      return w;
   endfunction

   task automatic fill_mem(input bit allow_wfi);
      for (int i = 0; i < 64; i++) mem[i] = {rand_word(allow_wfi), rand_word(allow_wfi)};
   endtask

   task automatic model_reset();
      m_pc      = 32'h0;
      m_q.delete();
      m_wait    = 0;
      m_discard = 0;
      m_halted  = 0;
   endtask

   task automatic model_push(input logic [63:0] line);
      logic [31:0] lo;
      logic [31:0] hi;
      lo = line[31:0];
      hi = line[63:32];
      if (m_pc[2]) begin
         m_q.push_back({m_pc, hi});
         if (hi == WFI) m_halted = 1;
         m_pc = m_pc + 32'd4;
      end else begin
         m_q.push_back({m_pc, lo});
         if (lo == WFI) begin
            m_halted = 1;
         end else begin
            m_q.push_back({m_pc + 32'd4, hi});
            if (hi == WFI) m_halted = 1;
         end
         m_pc = m_pc + 32'd8;
      end
   endtask

   // One clock: drive at negedge, compare 1ns later, then advance model and memory
   task automatic cycle(input bit rst, input bit dr, input bit rv, input logic [31:0] rpc);
      bit exp_req;
      bit hs;
      bit rsp;
      @(negedge clock);
      reset          = rst;
      dec_ready      = dr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      rsp            = !rst && (mem_cnt == 1);
      imem_resp_valid = rsp;
      imem_resp_data  = rsp ? mem[mem_addr[8:3]] : {$urandom, $urandom};
      #1;
      exp_req = !m_wait && !m_discard && !m_halted && !rv && ((DEPTH - m_q.size()) >= 2);
      if (!rst) begin
         check("req_valid", {63'h0, imem_req_valid}, {63'h0, exp_req});
         if (exp_req) check("req_addr", {32'h0, imem_req_addr}, {32'h0, m_pc[31:3], 3'b000});
         check("inst_valid", {63'h0, inst_valid}, {63'h0, m_q.size() != 0});
         if (m_q.size() != 0) begin
            check("inst_pc", {32'h0, inst_pc}, {32'h0, m_q[0][63:32]});
            check("inst", {32'h0, inst}, {32'h0, m_q[0][31:0]});
         end
         check("halted", {63'h0, halted}, {63'h0, m_halted});
      end
      hs = imem_req_valid && imem_req_ready;
      if (hs) req_log.push_back({32'h0, imem_req_addr});
      if (!rst && inst_valid && dr && !rv) pop_log.push_back({inst_pc, inst});
      if (rst) begin
         model_reset();
      end else if (rv) begin
         m_q.delete();
         m_pc      = rpc & 32'hFFFF_FFFC;
         m_halted  = 0;
         m_discard = (m_wait || m_discard) && !rsp;
         m_wait    = 0;
      end else begin
         if (dr && m_q.size() != 0) m_q.delete(0);
         if (exp_req && imem_req_ready) begin
            m_wait = 1;
         end else if (m_wait && rsp) begin
            model_push(imem_resp_data);
            m_wait = 0;
         end else if (m_discard && rsp) begin
            m_discard = 0;
         end
      end
      if (rst) begin
         mem_cnt = 0;
      end else begin
         if (mem_cnt > 0) mem_cnt--;
         if (hs) begin
            mem_cnt  = $urandom_range(lat_max, lat_min);
            mem_addr = imem_req_addr;
         end
      end
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      check("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
      check("rst_halted", {63'h0, halted}, 64'h0);
      check("rst_inst", {32'h0, inst}, 64'h0);
      check("rst_inst_pc", {32'h0, inst_pc}, 64'h0);
      req_log.delete();
      pop_log.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] exp_seq [4];
      bit reached;
      reset = 1; dec_ready = 0; redirect_valid = 0; redirect_pc = 0;
      imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
      mem_cnt = 0; mem_addr = 0; ready_pct = 100; lat_min = 1; lat_max = 1;
      model_reset();

      // Sequential fetch from reset up to a WFI in the high half
      fill_mem(0);
      mem[0] = 64'h00208133_00100093;
      mem[1] = 64'h10500073_002081b3;
      do_reset();
      repeat (20) cycle(0, 1, 0, 0);
      exp_seq[0] = {32'h0, 32'h00100093};
      exp_seq[1] = {32'h4, 32'h00208133};
      exp_seq[2] = {32'h8, 32'h002081b3};
      exp_seq[3] = {32'hC, 32'h10500073};
      check("seq_pop_count", pop_log.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("seq_pop%0d", i), pop_at(i), exp_seq[i]);
      check("seq_halted", {63'h0, halted}, 64'h1);
      check("seq_req_count", req_log.size(), 2);

      // Back-pressure: queue fills with four lines, then needs two pops to request again
      fill_mem(0);
      do_reset();
      repeat (20) cycle(0, 0, 0, 0);
      check("bp_req_count", req_log.size(), 4);
      check("bp_full_inst_valid", {63'h0, inst_valid}, 64'h1);
      check("bp_req_blocked", {63'h0, imem_req_valid}, 64'h0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
      check("bp_one_free", {63'h0, imem_req_valid}, 64'h0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
      check("bp_two_free", {63'h0, imem_req_valid}, 64'h1);
      check("bp_two_free_addr", {32'h0, imem_req_addr}, 64'h20);

      // Redirect to a word in the high half of a line
      fill_mem(0);
      do_reset();
      cycle(0, 1, 1, 32'h104);
      repeat (12) cycle(0, 1, 0, 0);
      check("mis_req0", req_at(0), 64'h100);
      check("mis_req1", req_at(1), 64'h108);
      check("mis_pop0", pop_at(0), {32'h104, mem[32][63:32]});
      check("mis_pop1_pc", {32'h0, pop_at(1)[63:32]}, 64'h108);

      // Redirect while a request is outstanding drops its response
      fill_mem(0);
      lat_min = 3; lat_max = 3;
      do_reset();
      cycle(0, 1, 1, 32'h40);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 32'h200);
      cycle(0, 1, 0, 0);
      check("out_flushed", {63'h0, inst_valid}, 64'h0);
      repeat (15) cycle(0, 1, 0, 0);
      check("out_req0", req_at(0), 64'h40);
      check("out_req1", req_at(1), 64'h200);
      check("out_pop0", pop_at(0), {32'h200, mem[64'h200 >> 3 & 63][31:0]});
      lat_min = 1; lat_max = 1;

      // WFI in the low half stops after one entry; redirect resumes
      fill_mem(0);
      mem[2] = 64'h00000013_10500073;
      do_reset();
      cycle(0, 1, 1, 32'h10);
      repeat (8) cycle(0, 1, 0, 0);
      check("wfi_pop_count", pop_log.size(), 1);
      check("wfi_pop0", pop_at(0), {32'h10, WFI});
      check("wfi_halted", {63'h0, halted}, 64'h1);
      cycle(0, 1, 1, 32'h0);
      cycle(0, 1, 0, 0);
      check("wfi_cleared", {63'h0, halted}, 64'h0);
      check("wfi_resume_req", {63'h0, imem_req_valid}, 64'h1);
      check("wfi_resume_addr", {32'h0, imem_req_addr}, 64'h0);

      // Two-entry push together with a pop at occupancy six
      fill_mem(0);
      do_reset();
      reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (req_log.size() == 4 && mem_cnt == 1) reached = 1;
         else cycle(0, 0, 0, 0);
      end
      check("pp_reached", {63'h0, reached}, 64'h1);
      cycle(0, 1, 0, 0);
      ready_pct = 0;
      cycle(0, 0, 0, 0);
      check("pp_no_req_at7", {63'h0, imem_req_valid}, 64'h0);
      pop_log.delete();
      repeat (10) cycle(0, 1, 0, 0);
      check("pp_drain_count", pop_log.size(), 7);
      for (int i = 0; i < 7; i++)
         check($sformatf("pp_order%0d", i), {32'h0, pop_at(i)[63:32]}, 64'(4 * (i + 1)));

      // Randomized traffic against the model
      ready_pct = 75; lat_min = 1; lat_max = 3;
      fill_mem(1);
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(499) == 0, $urandom_range(2) != 0,
               $urandom_range(24) == 0, 32'($urandom_range(511)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
